// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_pkg : shared types and default field widths for trace capture  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trace_pkg;

  localparam int TRACE_PC_W    = 32;
  localparam int TRACE_INSTR_W = 32;
  localparam int TRACE_TAG_W   = 8;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_POST = 2'd1,
    MODE_WRAP = 2'd2
  } trace_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]    pc;
    logic [TRACE_INSTR_W-1:0] instr;
    logic [TRACE_TAG_W-1:0]   tag;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_ram : DEPTH x W storage, one write port, one registered read   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 72
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Non-blocking read of the same slot being written returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/trace_capture_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_capture_unit : arm/trigger controlled retire-trace circular buf |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_capture_unit
  import trace_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int PC_W    = TRACE_PC_W,
  parameter int INSTR_W = TRACE_INSTR_W,
  parameter int TAG_W   = TRACE_TAG_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     arm_i,
  input  logic [1:0]               mode_i,
  input  logic [$clog2(DEPTH):0]   post_count_i,
  input  logic                     trigger_i,
  input  logic                     retire_valid_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic [INSTR_W-1:0]       instr_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic [1:0]               state_o,
  output logic                     triggered_o,
  output logic                     done_o,
  output logic [$clog2(DEPTH)-1:0] wr_ptr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH)-1:0] trig_idx_o,
  input  logic                     rd_req_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic                     rd_valid_o,
  output logic                     rd_err_o,
  output logic [PC_W-1:0]          rd_pc_o,
  output logic [INSTR_W-1:0]       rd_instr_o,
  output logic [TAG_W-1:0]         rd_tag_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INSTR_W + TAG_W;
  localparam logic [CW-1:0] C_FULL     = CW'(DEPTH);
  localparam logic [AW-1:0] C_MAX_POST = AW'(DEPTH - 1);

  trace_state_e  state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] post_q, post_d;
  logic [AW-1:0] remain_q, remain_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] trig_idx_q, trig_idx_d;
  logic          triggered_q, triggered_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_err_q, rd_err_d;

  logic          wr_en;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_phys;
  logic [EW-1:0] ram_rdata;

  assign wr_en = enable_i && retire_valid_i && !arm_i &&
                 (state_q == ST_ARMED || state_q == ST_POST);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    post_d      = post_q;
    remain_d    = remain_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    trig_idx_d  = trig_idx_q;
    triggered_d = triggered_q;
    if (arm_i) begin
      state_d     = ST_ARMED;
      mode_d      = mode_i;
      post_d      = (post_count_i > CW'(DEPTH - 1)) ? C_MAX_POST : post_count_i[AW-1:0];
      wr_ptr_d    = '0;
      count_d     = '0;
      trig_idx_d  = '0;
      triggered_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = (count_q == C_FULL) ? count_q : count_q + CW'(1);
      end
      case (state_q)
        ST_ARMED: begin
          if (enable_i && trigger_i && !triggered_q) begin
            triggered_d = 1'b1;
            // Without a write this cycle, the trigger attaches to the newest stored entry.
            trig_idx_d  = wr_en ? wr_ptr_q : wr_ptr_q - AW'(1);
            if (mode_q == MODE_WRAP) begin
              state_d = ST_ARMED;
            end else if (mode_q == MODE_POST) begin
              remain_d = post_q;
              state_d  = (post_q == '0) ? ST_DONE : ST_POST;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_POST: begin
          if (wr_en) begin
            remain_d = remain_q - AW'(1);
            if (remain_q == AW'(1)) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Logical index 0 is the oldest live entry; once full that is the next write slot.
  assign oldest  = (count_q == C_FULL) ? wr_ptr_q : '0;
  assign rd_phys = oldest + rd_addr_i;

  always_comb begin
    rd_valid_d = rd_req_i;
    rd_err_d   = rd_req_i && ({1'b0, rd_addr_i} >= count_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      post_q      <= '0;
      remain_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trig_idx_q  <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      post_q      <= post_d;
      remain_q    <= remain_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      trig_idx_q  <= trig_idx_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({pc_i, instr_i, tag_i}),
    .re_i    (rd_req_i),
    .raddr_i (rd_phys),
    .rdata_o (ram_rdata)
  );

  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign done_o      = (state_q == ST_DONE);
  assign wr_ptr_o    = wr_ptr_q;
  assign count_o     = count_q;
  assign trig_idx_o  = trig_idx_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_err_o    = rd_err_q;
  assign {rd_pc_o, rd_instr_o, rd_tag_o} = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_trace_capture_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trace_capture_unit : vector table plus read scoreboard, DEPTH=8    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_trace_capture_unit;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          enable_i, arm_i, trigger_i, retire_valid_i, rd_req_i;
  logic [1:0]    mode_i;
  logic [CW-1:0] post_count_i;
  logic [31:0]   pc_i, instr_i;
  logic [7:0]    tag_i;
  logic [1:0]    state_o;
  logic          triggered_o, done_o, rd_valid_o, rd_err_o;
  logic [AW-1:0] wr_ptr_o, trig_idx_o, rd_addr_i;
  logic [CW-1:0] count_o;
  logic [31:0]   rd_pc_o, rd_instr_o;
  logic [7:0]    rd_tag_o;

  always #5 clk_i = ~clk_i;

  trace_capture_unit #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32), .TAG_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .arm_i(arm_i),
    .mode_i(mode_i), .post_count_i(post_count_i), .trigger_i(trigger_i),
    .retire_valid_i(retire_valid_i), .pc_i(pc_i), .instr_i(instr_i), .tag_i(tag_i),
    .state_o(state_o), .triggered_o(triggered_o), .done_o(done_o),
    .wr_ptr_o(wr_ptr_o), .count_o(count_o), .trig_idx_o(trig_idx_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_valid_o(rd_valid_o),
    .rd_err_o(rd_err_o), .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o), .rd_tag_o(rd_tag_o)
  );

  typedef struct {
    logic          arm;
    logic [1:0]    mode;
    logic [CW-1:0] post;
    logic          trig;
    logic          ret;
    logic          en;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [AW-1:0] wp;
    logic          trg;
    logic [AW-1:0] tidx;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  tag;
  } rd_exp_t;

  int      checks = 0;
  int      errors = 0;
  int      rn;
  rd_exp_t rq[$];
  vec_t    tv[$];

  function automatic logic [31:0] pc_of(input int k);
    return 32'h100 + 32'(4 * (k - 1));
  endfunction

  function automatic logic [31:0] instr_of(input int k);
    return 32'hA000_0000 | 32'(k);
  endfunction

  function automatic vec_t mk(input logic arm, input logic [1:0] mode, input int post,
                              input logic trig, input logic ret, input logic en,
                              input int st, input int cnt, input int wp,
                              input logic trg, input int tidx);
    vec_t v;
    v.arm = arm; v.mode = mode; v.post = CW'(post); v.trig = trig; v.ret = ret; v.en = en;
    v.st = 2'(st); v.cnt = CW'(cnt); v.wp = AW'(wp); v.trg = trg; v.tidx = AW'(tidx);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_st(input string name, input int st, input int cnt, input int wp,
                          input logic trg, input int tidx);
    check({name, ".state"}, 64'(state_o), 64'(st));
    check({name, ".count"}, 64'(count_o), 64'(cnt));
    check({name, ".wr_ptr"}, 64'(wr_ptr_o), 64'(wp));
    check({name, ".triggered"}, 64'(triggered_o), 64'(trg));
    check({name, ".trig_idx"}, 64'(trig_idx_o), 64'(tidx));
    check({name, ".done"}, 64'(done_o), 64'(st == 3));
  endtask

  // One clock of stimulus; retire payloads come from the running retire number rn.
  task automatic step(input logic arm, input logic [1:0] mode, input int post,
                      input logic trig, input logic ret, input logic en);
    arm_i = arm; mode_i = mode; post_count_i = CW'(post);
    trigger_i = trig; retire_valid_i = ret; enable_i = en;
    if (ret) begin
      pc_i = pc_of(rn); instr_i = instr_of(rn); tag_i = 8'(rn);
      rn++;
    end
    @(posedge clk_i); #1;
    arm_i = 1'b0; trigger_i = 1'b0; retire_valid_i = 1'b0; enable_i = 1'b1; rd_req_i = 1'b0;
  endtask

  // k = retire number whose entry is expected; k = 0 means zero data.
  task automatic rd_issue(input int addr, input logic err, input int k);
    rd_exp_t e;
    e.err   = err;
    e.pc    = (k == 0) ? 32'h0 : pc_of(k);
    e.instr = (k == 0) ? 32'h0 : instr_of(k);
    e.tag   = 8'(k);
    rq.push_back(e);
    rd_req_i  = 1'b1;
    rd_addr_i = AW'(addr);
  endtask

  task automatic do_read(input string name, input int addr, input logic err, input int k);
    rd_issue(addr, err, k);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check({name, ".rd_latency"}, 64'(rq.size()), 64'(0));
    rq.delete();
  endtask

  always @(negedge clk_i) begin
    rd_exp_t e;
    if (rd_valid_o) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rd_valid 1 expected 0");
      end else begin
        e = rq.pop_front();
        check("rd_err", 64'(rd_err_o), 64'(e.err));
        check("rd_pc", 64'(rd_pc_o), 64'(e.pc));
        check("rd_instr", 64'(rd_instr_o), 64'(e.instr));
        check("rd_tag", 64'(rd_tag_o), 64'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; arm_i = 1'b0; mode_i = 2'd0; post_count_i = '0;
    trigger_i = 1'b0; retire_valid_i = 1'b0; pc_i = '0; instr_i = '0; tag_i = '0;
    rd_req_i = 1'b0; rd_addr_i = '0; rn = 1;
    repeat (3) @(posedge clk_i);
    #1;
    check_st("reset", 0, 0, 0, 0, 0);
    check("reset.rd_valid", 64'(rd_valid_o), 64'(0));
    check("reset.rd_err", 64'(rd_err_o), 64'(0));
    check("reset.rd_pc", 64'(rd_pc_o), 64'(0));
    rst_ni = 1'b1;
    step(0, 0, 0, 0, 1, 1);
    check_st("idle_no_capture", 0, 0, 0, 0, 0);

    // STOP mode as a vector table: 5 retires, trigger on the 6th, later activity ignored.
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, k, k, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 3, 6, 6, 1, 5));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 3, 6, 6, 1, 5));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 3, 6, 6, 1, 5));
    rn = 1;
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].arm, tv[i].mode, int'(tv[i].post), tv[i].trig, tv[i].ret, tv[i].en);
      check_st($sformatf("stop_v%0d", i), int'(tv[i].st), int'(tv[i].cnt), int'(tv[i].wp),
               tv[i].trg, int'(tv[i].tidx));
    end
    do_read("stop_rd5", 5, 0, 6);

    // STOP with wrap: 11 retires then a trigger with no retire.
    rn = 1;
    step(1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 11; k++) step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 1);
    check_st("stopwrap", 3, 8, 3, 1, 2);
    do_read("stopwrap_rd0", 0, 0, 4);
    do_read("stopwrap_rd7", 7, 0, 11);

    // POST mode with a 3-entry window after the trigger on the 4th retire.
    rn = 1;
    step(1, 1, 3, 0, 0, 1);
    for (int k = 1; k <= 3; k++) step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    check_st("post_trig", 2, 4, 4, 1, 3);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    check_st("post_mid", 2, 6, 6, 1, 3);
    step(0, 0, 0, 0, 1, 1);
    check_st("post_done", 3, 7, 7, 1, 3);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    check_st("post_hold", 3, 7, 7, 1, 3);
    do_read("post_rd6", 6, 0, 7);
    do_read("post_rd7_err", 7, 1, 0);

    // WRAP: triggers at retire 10 and 15, only the first is recorded.
    rn = 1;
    step(1, 2, 0, 0, 0, 1);
    for (int k = 1; k <= 20; k++) step(0, 0, 0, (k == 10 || k == 15), 1, 1);
    check_st("wrap", 1, 8, 4, 1, 1);
    rd_issue(0, 0, 13);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_rbw.rd_latency", 64'(rq.size()), 64'(0));
    rq.delete();
    check_st("wrap_after", 1, 8, 5, 1, 1);
    do_read("wrap_rd7", 7, 0, 21);

    // Out-of-range read and disabled trigger/retire.
    rn = 1;
    step(1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 0, 1, 1);
    do_read("oob_rd6", 6, 1, 0);
    do_read("inrange_rd3", 3, 0, 4);
    step(0, 0, 0, 1, 1, 0);
    check_st("disabled", 1, 4, 4, 0, 0);

    // Asynchronous reset while in POST.
    rn = 1;
    step(1, 1, 5, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    check_st("prerst", 2, 3, 3, 1, 2);
    #2 rst_ni = 1'b0;
    #1;
    check_st("async_rst", 0, 0, 0, 0, 0);
    check("async_rst.rd_valid", 64'(rd_valid_o), 64'(0));
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Re-arm during POST with a simultaneous trigger and retire.
    rn = 1;
    step(1, 1, 5, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    check_st("post_again", 2, 2, 2, 1, 1);
    step(1, 1, 5, 1, 1, 1);
    check_st("rearm", 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
